// File: rtl/cond_flag_unit_pkg.sv
// cond_pkg: shared definitions for the condition-flag unit.
// Holds the condition-code values, the FSM state encoding, the bit
// positions of each flag in the {L,C,V,N,Z} vector, and cond_eval(), which
// decodes one code against one flag vector.
package cond_pkg;

  // Condition codes, q_code[3:0]. q_code[4] inverts the result.
  localparam logic [3:0] CC_ALWAYS  = 4'd0;
  localparam logic [3:0] CC_Z       = 4'd1;
  localparam logic [3:0] CC_N       = 4'd2;
  localparam logic [3:0] CC_V       = 4'd3;
  localparam logic [3:0] CC_C       = 4'd4;
  localparam logic [3:0] CC_CNZ     = 4'd5;   // C & ~Z
  localparam logic [3:0] CC_NEQV    = 4'd6;   // N == V
  localparam logic [3:0] CC_GT      = 4'd7;   // ~Z & (N == V)
  localparam logic [3:0] CC_L       = 4'd8;
  localparam logic [3:0] CC_ZORC    = 4'd9;   // Z | C
  localparam logic [3:0] CC_RSVD_LO = 4'd10;  // first reserved code

  // Flag vector field indices: flags = {L,C,V,N,Z}.
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_C = 3;
  localparam int FLAG_L = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } condState_t;

  // Returns {taken, illegal}. Reserved codes are never taken, even when
  // the invert bit is set.
  function automatic logic [1:0] cond_eval(input logic [4:0] code,
                                           input logic [4:0] flagVec);
    logic z, n, v, c, l;
    logic raw;
    logic illegal;
    z       = flagVec[FLAG_Z];
    n       = flagVec[FLAG_N];
    v       = flagVec[FLAG_V];
    c       = flagVec[FLAG_C];
    l       = flagVec[FLAG_L];
    raw     = 1'b0;
    illegal = 1'b0;
    case (code[3:0])
      CC_ALWAYS: raw = 1'b1;
      CC_Z:      raw = z;
      CC_N:      raw = n;
      CC_V:      raw = v;
      CC_C:      raw = c;
      CC_CNZ:    raw = c & ~z;
      CC_NEQV:   raw = (n == v);
      CC_GT:     raw = ~z & (n == v);
      CC_L:      raw = l;
      CC_ZORC:   raw = z | c;
      default:   illegal = 1'b1;
    endcase
    if (illegal) return {1'b0, 1'b1};
    return {raw ^ code[4], 1'b0};
  endfunction

endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: query/response channel between the branch stage and
// the condition-flag unit.
//   q_valid/q_code/q_ready     : condition query handshake
//   r_valid/r_taken/r_illegal  : held response
//   r_ready                    : response consumed
// master = branch stage, slave = cond_flag_unit.
interface cond_flag_unit_if;
  logic       q_valid;
  logic [4:0] q_code;
  logic       q_ready;
  logic       r_valid;
  logic       r_taken;
  logic       r_illegal;
  logic       r_ready;

  modport master (
    output q_valid, q_code, r_ready,
    input  q_ready, r_valid, r_taken, r_illegal
  );

  modport slave (
    input  q_valid, q_code, r_ready,
    output q_ready, r_valid, r_taken, r_illegal
  );
endinterface

// File: rtl/cond_flag_unit_eval.sv
// cond_eval_comb: combinational decode of one condition code against one
// flag vector.
//   code    in  5  condition code (bit 4 inverts)
//   flagVec in  5  {L,C,V,N,Z}
//   taken   out 1  condition true
//   illegal out 1  reserved code
module cond_eval_comb
  import cond_pkg::*;
(
  input  logic [4:0] code,
  input  logic [4:0] flagVec,
  output logic       taken,
  output logic       illegal
);
  assign {taken, illegal} = cond_eval(code, flagVec);
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: flag register plus branch-condition responder.
// Captures ALU flags on set-flags results, counts in-flight flag writers,
// and answers condition queries once the flags are current.
//   clk, rst_n         clock, synchronous active-low reset
//   iss_valid/ready    issue of a flag-setting op
//   alu_*              ALU result and status bits; alu_valid&alu_setf retires
//   qIf (slave)        query/response channel
//   flag_err           sticky: retire seen with nothing pending
//   flags              {L,C,V,N,Z}
module cond_flag_unit
  import cond_pkg::*;
#(
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic              alu_setf,
  input  logic              alu_sum,
  input  logic              alu_a_msb,
  input  logic              alu_b_msb,
  input  logic              alu_r_msb,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_a_lsb,
  cond_flag_unit_if.slave   qIf,
  output logic              flag_err,
  output logic [4:0]        flags
);
  localparam int              PW       = $clog2(MAX_PEND + 1);
  localparam logic [PW-1:0]   PEND_MAX = PW'(MAX_PEND);
  localparam logic [PW-1:0]   PEND_ONE = PW'(1);

  condState_t    state, stateNext;
  logic [PW-1:0] pendCnt, pendNext;
  logic [4:0]    flagReg, capFlags, fwdFlags, evalCode;
  logic [4:0]    codeReg, codeNext;
  logic          errReg, errNext;
  logic          takenReg, takenNext, illegalReg, illegalNext;
  logic          issFire, retire, lastWriter, flagsCurrent;
  logic          evalTaken, evalIllegal;

  assign iss_ready = (pendCnt < PEND_MAX);
  assign issFire   = iss_valid & iss_ready;
  assign retire    = alu_valid & alu_setf;

  always_comb begin
    capFlags         = '0;
    capFlags[FLAG_Z] = alu_zero;
    capFlags[FLAG_N] = alu_r_msb;
    capFlags[FLAG_C] = alu_carry;
    capFlags[FLAG_L] = alu_a_lsb;
    // Signed overflow: like-signed operands giving a differently-signed result.
    capFlags[FLAG_V] = alu_sum & (alu_a_msb == alu_b_msb) & (alu_r_msb != alu_a_msb);
  end

  // The last in-flight writer retiring this cycle makes the flags current;
  // the query then sees its result through the forwarding mux.
  assign lastWriter   = (pendCnt == PEND_ONE) & retire;
  assign flagsCurrent = (pendCnt == '0) | lastWriter;
  assign fwdFlags     = lastWriter ? capFlags : flagReg;
  assign evalCode     = (state == ST_IDLE) ? qIf.q_code : codeReg;

  cond_eval_comb uEval (
    .code    (evalCode),
    .flagVec (fwdFlags),
    .taken   (evalTaken),
    .illegal (evalIllegal)
  );

  always_comb begin
    pendNext = pendCnt;
    errNext  = errReg;
    if (issFire && !retire) begin
      pendNext = pendCnt + PEND_ONE;
    end else if (retire && !issFire && pendCnt != '0) begin
      pendNext = pendCnt - PEND_ONE;
    end
    if (retire && pendCnt == '0) errNext = 1'b1;
  end

  always_comb begin
    stateNext    = state;
    codeNext     = codeReg;
    takenNext    = takenReg;
    illegalNext  = illegalReg;
    qIf.q_ready  = 1'b0;
    qIf.r_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        qIf.q_ready = 1'b1;
        if (qIf.q_valid) begin
          codeNext = qIf.q_code;
          if (flagsCurrent) begin
            stateNext   = ST_RESP;
            takenNext   = evalTaken;
            illegalNext = evalIllegal;
          end else begin
            stateNext = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (flagsCurrent) begin
          stateNext   = ST_RESP;
          takenNext   = evalTaken;
          illegalNext = evalIllegal;
        end
      end
      ST_RESP: begin
        qIf.r_valid = 1'b1;
        if (qIf.r_ready) begin
          stateNext   = ST_IDLE;
          takenNext   = 1'b0;
          illegalNext = 1'b0;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // State / flag register boundary
  always_ff @(posedge clk) begin
    codeReg <= codeNext;
    if (!rst_n) begin
      state      <= ST_IDLE;
      pendCnt    <= '0;
      flagReg    <= '0;
      errReg     <= 1'b0;
      takenReg   <= 1'b0;
      illegalReg <= 1'b0;
    end else begin
      state      <= stateNext;
      pendCnt    <= pendNext;
      errReg     <= errNext;
      takenReg   <= takenNext;
      illegalReg <= illegalNext;
      if (retire) flagReg <= capFlags;
    end
  end

  assign qIf.r_taken   = takenReg;
  assign qIf.r_illegal = illegalReg;
  assign flag_err      = errReg;
  assign flags         = flagReg;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: V detection, stall/forwarding,
// backpressure, reserved codes, pending limits and mid-query reset.
module tb_cond_flag_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       iss_valid, iss_ready;
  logic       alu_valid, alu_setf, alu_sum;
  logic       alu_a_msb, alu_b_msb, alu_r_msb;
  logic       alu_zero, alu_carry, alu_a_lsb;
  logic       flag_err;
  logic [4:0] flags;
  int         checks = 0;
  int         errors = 0;

  cond_flag_unit_if qIf ();

  cond_flag_unit #(.MAX_PEND(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .alu_valid (alu_valid),
    .alu_setf  (alu_setf),
    .alu_sum   (alu_sum),
    .alu_a_msb (alu_a_msb),
    .alu_b_msb (alu_b_msb),
    .alu_r_msb (alu_r_msb),
    .alu_zero  (alu_zero),
    .alu_carry (alu_carry),
    .alu_a_lsb (alu_a_lsb),
    .qIf       (qIf.slave),
    .flag_err  (flag_err),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aluIdle();
    alu_valid = 0; alu_setf = 0; alu_sum = 0; alu_a_msb = 0; alu_b_msb = 0;
    alu_r_msb = 0; alu_zero = 0; alu_carry = 0; alu_a_lsb = 0;
  endtask

  task automatic retireOp(input logic sum, input logic am, input logic bm,
                          input logic rm, input logic z, input logic c, input logic l);
    alu_valid = 1; alu_setf = 1; alu_sum = sum; alu_a_msb = am; alu_b_msb = bm;
    alu_r_msb = rm; alu_zero = z; alu_carry = c; alu_a_lsb = l;
  endtask

  task automatic query(input logic [4:0] code);
    qIf.q_valid = 1; qIf.q_code = code;
  endtask

  // One accepted response: assert r_ready for a cycle, then drop it.
  task automatic release_resp();
    qIf.q_valid = 0; qIf.r_ready = 1;
    tick();
    qIf.r_ready = 0;
  endtask

  initial begin
    rst_n = 0; iss_valid = 0; aluIdle();
    qIf.q_valid = 0; qIf.q_code = '0; qIf.r_ready = 0;
    tick(); tick();
    rst_n = 1;
    check("rst_q_ready", qIf.q_ready, 1);
    check("rst_iss_ready", iss_ready, 1);
    check("rst_r_valid", qIf.r_valid, 0);
    check("rst_r_taken", qIf.r_taken, 0);
    check("rst_r_illegal", qIf.r_illegal, 0);
    check("rst_flags", flags, 0);
    check("rst_flag_err", flag_err, 0);

    // V detection: positive + positive giving negative
    iss_valid = 1; tick(); iss_valid = 0;
    retireOp(1, 0, 0, 1, 0, 0, 0); tick(); aluIdle();
    check("v_flags", flags, 8'h06);
    check("v_no_err", flag_err, 0);
    query(5'h03); tick(); qIf.q_valid = 0;
    check("v_r_valid", qIf.r_valid, 1);
    check("v_taken", qIf.r_taken, 1);
    check("v_illegal", qIf.r_illegal, 0);
    check("v_q_ready_resp", qIf.q_ready, 0);
    release_resp();
    check("v_back_idle", qIf.q_ready, 1);
    query(5'h13); tick(); qIf.q_valid = 0;
    check("nv_r_valid", qIf.r_valid, 1);
    check("nv_taken", qIf.r_taken, 0);
    release_resp();

    // Stall until the last of two writers retires
    iss_valid = 1; tick(); tick(); iss_valid = 0;
    query(5'h01); tick(); qIf.q_valid = 0;
    check("stall_wait_rv", qIf.r_valid, 0);
    check("stall_wait_qr", qIf.q_ready, 0);
    retireOp(0, 0, 0, 0, 1, 0, 0); tick();
    check("stall_after1_rv", qIf.r_valid, 0);
    tick(); aluIdle();
    check("stall_after2_rv", qIf.r_valid, 1);
    check("stall_taken", qIf.r_taken, 1);
    check("stall_flags", flags, 8'h01);
    release_resp();

    // Forwarding: query with the last writer retiring in the same cycle
    iss_valid = 1; tick(); iss_valid = 0;
    retireOp(0, 0, 0, 0, 0, 0, 0); tick(); aluIdle();
    check("fwd_flags_clear", flags, 0);
    iss_valid = 1; tick(); iss_valid = 0;
    query(5'h01); retireOp(0, 0, 0, 0, 1, 0, 0); tick(); aluIdle(); qIf.q_valid = 0;
    check("fwd_r_valid", qIf.r_valid, 1);
    check("fwd_taken", qIf.r_taken, 1);
    release_resp();

    // Backpressure: held response ignores a later Z change
    query(5'h01); tick(); qIf.q_valid = 0;
    check("bp_r_valid0", qIf.r_valid, 1);
    iss_valid = 1; tick(); iss_valid = 0;
    retireOp(0, 0, 0, 0, 0, 0, 0); tick(); aluIdle();
    check("bp_flags_changed", flags, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_r_valid", qIf.r_valid, 1);
      check("bp_r_taken", qIf.r_taken, 1);
      check("bp_q_ready", qIf.q_ready, 0);
    end
    release_resp();
    check("bp_rel_r_valid", qIf.r_valid, 0);
    check("bp_rel_q_ready", qIf.q_ready, 1);

    // Reserved code, then a stray retire
    query(5'h1C); tick(); qIf.q_valid = 0;
    check("rsv_taken", qIf.r_taken, 0);
    check("rsv_illegal", qIf.r_illegal, 1);
    release_resp();
    retireOp(0, 0, 0, 0, 1, 1, 1); tick(); aluIdle();
    check("err_set", flag_err, 1);
    check("err_flags_updated", flags, 8'h19);
    tick(); tick();
    check("err_sticky", flag_err, 1);

    // Pending limit, blocked issue with retire, then reset in WAIT
    iss_valid = 1; tick(); tick();
    check("lim_ready_2", iss_ready, 1);
    tick();
    check("lim_ready_3", iss_ready, 0);
    retireOp(0, 0, 0, 0, 0, 0, 0); tick(); aluIdle(); iss_valid = 0;
    check("lim_drop_to_2", iss_ready, 1);
    iss_valid = 1; tick(); iss_valid = 0;
    check("lim_count_was_2", iss_ready, 0);
    query(5'h00); tick(); qIf.q_valid = 0;
    check("rstw_in_wait", qIf.q_ready, 0);
    rst_n = 0; tick(); rst_n = 1;
    check("rstw_q_ready", qIf.q_ready, 1);
    check("rstw_r_valid", qIf.r_valid, 0);
    check("rstw_iss_ready", iss_ready, 1);
    check("rstw_flag_err", flag_err, 0);
    check("rstw_flags", flags, 0);
    query(5'h00); tick(); qIf.q_valid = 0;
    check("rstw_pend0_resp", qIf.r_valid, 1);
    check("rstw_always", qIf.r_taken, 1);
    release_resp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
